// File: rtl/i2c_init_seq_axil.sv
// Table-driven I2C init sequencer: an AXI-lite master that programs an I2C master's registers.
// Macro I2C_SEQ_RETRY_EN adds per-entry retries on a missed ACK (default build: no retries).
module i2c_init_seq_axil #(
  parameter int          TBL_AW     = 6,
  parameter logic [15:0] PRESCALE   = 16'd250,
  parameter int          POLL_LIMIT = 4096,
  parameter int          MAX_RETRY  = 3
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [TBL_AW-1:0] err_index,
  output logic [TBL_AW-1:0] tbl_addr,
  output logic              tbl_en,
  input  logic [24:0]       tbl_data,
  output logic [3:0]        m_axil_awaddr,
  output logic [2:0]        m_axil_awprot,
  output logic              m_axil_awvalid,
  input  logic              m_axil_awready,
  output logic [31:0]       m_axil_wdata,
  output logic [3:0]        m_axil_wstrb,
  output logic              m_axil_wvalid,
  input  logic              m_axil_wready,
  input  logic [1:0]        m_axil_bresp,
  input  logic              m_axil_bvalid,
  output logic              m_axil_bready,
  output logic [3:0]        m_axil_araddr,
  output logic [2:0]        m_axil_arprot,
  output logic              m_axil_arvalid,
  input  logic              m_axil_arready,
  input  logic [31:0]       m_axil_rdata,
  input  logic [1:0]        m_axil_rresp,
  input  logic              m_axil_rvalid,
  output logic              m_axil_rready
);

  localparam int PCW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRESC, S_FETCH, S_LATCH, S_CLRACK, S_WREG,
    S_WDAT, S_WCMD, S_POLL, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t            state_q;
  logic              busy_q, done_q, error_q, tbl_en_q, xact_q, missed_ack_q;
  logic [1:0]        err_code_q;
  logic [TBL_AW-1:0] err_index_q, tbl_addr_q;
  logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [3:0]        awaddr_q;
  logic [31:0]       wdata_q;
  logic [PCW-1:0]    poll_cnt_q;
  logic              last_q;
  logic [6:0]        dev_q;
  logic [7:0]        reg_q, dat_q;
`ifdef I2C_SEQ_RETRY_EN
  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RCW-1:0]    retry_q;
`endif

  logic [3:0]  wr_addr_d;
  logic [31:0] wr_data_d;
  state_t      wr_next_d;

  // Address, payload and successor of whichever register write the current state performs.
  always_comb begin
    wr_addr_d = 4'h0;
    wr_data_d = 32'h0;
    wr_next_d = S_IDLE;
    unique case (state_q)
      S_PRESC:  begin wr_addr_d = 4'hC; wr_data_d = {16'h0, PRESCALE};          wr_next_d = S_FETCH; end
      S_CLRACK: begin wr_addr_d = 4'h0; wr_data_d = 32'h8;                      wr_next_d = S_WREG;  end
      S_WREG:   begin wr_addr_d = 4'h8; wr_data_d = {24'h0, reg_q};             wr_next_d = S_WDAT;  end
      S_WDAT:   begin wr_addr_d = 4'h8; wr_data_d = {22'h0, 2'b10, dat_q};      wr_next_d = S_WCMD;  end
      S_WCMD:   begin wr_addr_d = 4'h4; wr_data_d = {19'h0, 5'b11001, 1'b0, dev_q}; wr_next_d = S_POLL; end
      default:  ;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= 2'd0;
      err_index_q  <= '0;
      tbl_addr_q   <= '0;
      tbl_en_q     <= 1'b0;
      xact_q       <= 1'b0;
      missed_ack_q <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awaddr_q     <= 4'h0;
      wdata_q      <= 32'h0;
      poll_cnt_q   <= '0;
      last_q       <= 1'b0;
      dev_q        <= 7'h0;
      reg_q        <= 8'h0;
      dat_q        <= 8'h0;
`ifdef I2C_SEQ_RETRY_EN
      retry_q      <= '0;
`endif
    end else begin
      done_q   <= 1'b0;
      tbl_en_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (start) begin
          busy_q     <= 1'b1;
          error_q    <= 1'b0;
          err_code_q <= 2'd0;
          tbl_addr_q <= '0;
`ifdef I2C_SEQ_RETRY_EN
          retry_q    <= '0;
`endif
          state_q    <= S_PRESC;
        end
        S_PRESC, S_CLRACK, S_WREG, S_WDAT, S_WCMD: begin
          if (!xact_q) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            bready_q  <= 1'b1;
            awaddr_q  <= wr_addr_d;
            wdata_q   <= wr_data_d;
            xact_q    <= 1'b1;
          end else begin
            if (awvalid_q && m_axil_awready) awvalid_q <= 1'b0;
            if (wvalid_q && m_axil_wready)   wvalid_q  <= 1'b0;
            if (bready_q && m_axil_bvalid) begin
              bready_q <= 1'b0;
              xact_q   <= 1'b0;
              if (m_axil_bresp != 2'b00) begin
                err_code_q <= 2'd2;
                state_q    <= S_ERROR;
              end else begin
                state_q    <= wr_next_d;
                tbl_en_q   <= (wr_next_d == S_FETCH);
                poll_cnt_q <= '0;
              end
            end
          end
        end
        S_FETCH: state_q <= S_LATCH;
        S_LATCH: begin
          last_q  <= tbl_data[24];
          dev_q   <= tbl_data[22:16];
          reg_q   <= tbl_data[15:8];
          dat_q   <= tbl_data[7:0];
          state_q <= S_CLRACK;
        end
        S_POLL: begin
          if (!xact_q) begin
            arvalid_q <= 1'b1;
            rready_q  <= 1'b1;
            xact_q    <= 1'b1;
          end else begin
            if (arvalid_q && m_axil_arready) arvalid_q <= 1'b0;
            if (rready_q && m_axil_rvalid) begin
              rready_q <= 1'b0;
              xact_q   <= 1'b0;
              if (m_axil_rresp != 2'b00) begin
                err_code_q <= 2'd2;
                state_q    <= S_ERROR;
              end else if (!m_axil_rdata[0] && m_axil_rdata[8]) begin
                missed_ack_q <= m_axil_rdata[3];
                state_q      <= S_CHECK;
              end else if (poll_cnt_q == PCW'(POLL_LIMIT - 1)) begin
                err_code_q <= 2'd3;
                state_q    <= S_ERROR;
              end else begin
                poll_cnt_q <= poll_cnt_q + 1'b1;
              end
            end
          end
        end
        S_CHECK: begin
          if (missed_ack_q) begin
`ifdef I2C_SEQ_RETRY_EN
            if (retry_q == RCW'(MAX_RETRY)) begin
              err_code_q <= 2'd1;
              state_q    <= S_ERROR;
            end else begin
              retry_q <= retry_q + 1'b1;
              state_q <= S_CLRACK;
            end
`else
            err_code_q <= 2'd1;
            state_q    <= S_ERROR;
`endif
          end else if (last_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            // Without a last flag the index simply wraps around the table.
            tbl_addr_q <= tbl_addr_q + 1'b1;
            tbl_en_q   <= 1'b1;
`ifdef I2C_SEQ_RETRY_EN
            retry_q    <= '0;
`endif
            state_q    <= S_FETCH;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ERROR: begin
          error_q     <= 1'b1;
          err_index_q <= tbl_addr_q;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{m_axil_rdata[31:9], m_axil_rdata[7:4], m_axil_rdata[2:1], tbl_data[23]};

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign err_code       = err_code_q;
  assign err_index      = err_index_q;
  assign tbl_addr       = tbl_addr_q;
  assign tbl_en         = tbl_en_q;
  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = 4'hF;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = 4'h0;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule
